// File: rtl/bcd_serial_add_ctrl.sv
// Multi-digit packed-BCD adder controller: one shared digit adder, LSD first, one digit per clock.
// Optional macro BCD_DIGIT_CHECK_EN flags operands containing non-BCD digits at capture.
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_input,
  input  logic [4*DIGITS-1:0]   A_input,
  input  logic [4*DIGITS-1:0]   B_input,
  input  logic                  Carry_input,
  output logic                  busy_output,
  output logic                  done_output,
  output logic [4*DIGITS-1:0]   Sum_output,
  output logic                  Carry_output,
  output logic                  error_output
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state_reg, state_next;
  logic [W-1:0]     a_reg, b_reg;
  logic [3:0]       sum_dig_reg [DIGITS];
  logic [IDX_W-1:0] idx_reg;
  logic             carry_reg, cout_reg;
  logic             capture, add_en;
  logic [3:0]       a_dig, b_dig, dig_res;
  logic [4:0]       dig_sum;
  logic             carry_next;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_input) state_next = ADD;
      ADD:     if (idx_reg == LAST_IDX) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    capture     = (state_reg == IDLE) && start_input;
    add_en      = (state_reg == ADD);
    busy_output = (state_reg != IDLE);
    done_output = (state_reg == DONE);
  end

  // Select the current digit pair and apply the decimal correction
  always_comb begin
    a_dig = 4'd0;
    b_dig = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_reg == IDX_W'(i)) begin
        a_dig = a_reg[4*i +: 4];
        b_dig = b_reg[4*i +: 4];
      end
    end
    dig_sum = {1'b0, a_dig} + {1'b0, b_dig} + {4'd0, carry_reg};
    if (dig_sum > 5'd9) begin
      dig_res    = dig_sum[3:0] + 4'd6;
      carry_next = 1'b1;
    end else begin
      dig_res    = dig_sum[3:0];
      carry_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
      cout_reg  <= 1'b0;
    end else if (capture) begin
      a_reg     <= A_input;
      b_reg     <= B_input;
      carry_reg <= Carry_input;
      idx_reg   <= '0;
      cout_reg  <= 1'b0;
    end else if (add_en) begin
      carry_reg <= carry_next;
      idx_reg   <= idx_reg + IDX_W'(1);
      if (idx_reg == LAST_IDX) cout_reg <= carry_next;
    end
  end

  // One result register per digit; only the addressed digit is written each ADD cycle
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_sum
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          sum_dig_reg[gi] <= 4'd0;
        else if (capture)
          sum_dig_reg[gi] <= 4'd0;
        else if (add_en && (idx_reg == IDX_W'(gi)))
          sum_dig_reg[gi] <= dig_res;
      end
      assign Sum_output[4*gi +: 4] = sum_dig_reg[gi];
    end
  endgenerate

  assign Carry_output = cout_reg;

`ifdef BCD_DIGIT_CHECK_EN
  logic err_reg, err_next;

  always_comb begin
    err_next = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((A_input[4*i +: 4] > 4'd9) || (B_input[4*i +: 4] > 4'd9)) err_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          err_reg <= 1'b0;
    else if (capture) err_reg <= err_next;
  end

  assign error_output = err_reg;
`else
  assign error_output = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed self-checking bench for bcd_serial_add_ctrl (DIGITS=4) with hand-computed results.
module tb_bcd_serial_add_ctrl;

  localparam int DIGITS = 4;
`ifdef BCD_DIGIT_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start_input;
  logic [15:0] A_input, B_input;
  logic        Carry_input;
  logic        busy_output, done_output, Carry_output, error_output;
  logic [15:0] Sum_output;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int d0;

  bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_input  (start_input),
    .A_input      (A_input),
    .B_input      (B_input),
    .Carry_input  (Carry_input),
    .busy_output  (busy_output),
    .done_output  (done_output),
    .Sum_output   (Sum_output),
    .Carry_output (Carry_output),
    .error_output (error_output)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done_output === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present operands with start for one clock; returns 1 ns after the capture edge
  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic c);
    @(negedge clk);
    A_input = a; B_input = b; Carry_input = c; start_input = 1'b1;
    @(posedge clk); #1;
    start_input = 1'b0;
  endtask

  // Wait (bounded) for done, then check cycle count, busy count and result
  task automatic finish_op(input string tag, input int exp_cyc, input int exp_bcnt,
                           input logic [15:0] exp_sum, input logic exp_c, input logic exp_err);
    int cyc;
    int bcnt;
    cyc  = 0;
    bcnt = (busy_output === 1'b1) ? 1 : 0;
    while (done_output !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (busy_output === 1'b1) bcnt++;
    end
    check({tag, " latency"}, cyc, exp_cyc);
    check({tag, " busy_cycles"}, bcnt, exp_bcnt);
    check({tag, " sum"}, {16'd0, Sum_output}, {16'd0, exp_sum});
    check({tag, " carry"}, {31'd0, Carry_output}, {31'd0, exp_c});
    check({tag, " error"}, {31'd0, error_output}, {31'd0, exp_err});
    $display("op %s: sum=%04h carry=%0b error=%0b cycles=%0d", tag, Sum_output, Carry_output,
             error_output, cyc);
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic [15:0] exp_sum, input logic exp_c,
                        input logic exp_err);
    launch(a, b, c);
    check({tag, " busy_at_capture"}, {31'd0, busy_output}, 32'd1);
    check({tag, " sum_cleared"}, {16'd0, Sum_output}, 32'd0);
    finish_op(tag, DIGITS, DIGITS + 1, exp_sum, exp_c, exp_err);
    @(posedge clk); #1;
    check({tag, " done_one_cycle"}, {31'd0, done_output}, 32'd0);
    check({tag, " idle_after_done"}, {31'd0, busy_output}, 32'd0);
    check({tag, " sum_held"}, {16'd0, Sum_output}, {16'd0, exp_sum});
  endtask

  initial begin
    rst = 1'b1; start_input = 1'b0; A_input = '0; B_input = '0; Carry_input = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", {31'd0, busy_output}, 32'd0);
    check("reset done", {31'd0, done_output}, 32'd0);
    check("reset sum", {16'd0, Sum_output}, 32'd0);
    check("reset carry", {31'd0, Carry_output}, 32'd0);
    check("reset error", {31'd0, error_output}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("1234+5678", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
    run_op("9999+0001", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);

    // Start held high through DONE is taken on the first IDLE cycle
    launch(16'h0000, 16'h0000, 1'b1);
    finish_op("0+0+c", DIGITS, DIGITS + 1, 16'h0001, 1'b0, 1'b0);
    A_input = 16'h4999; B_input = 16'h5000; Carry_input = 1'b0; start_input = 1'b1;
    @(posedge clk); #1;
    check("b2b idle_gap busy", {31'd0, busy_output}, 32'd0);
    check("b2b idle_gap sum", {16'd0, Sum_output}, 32'h0001);
    @(posedge clk); #1;
    start_input = 1'b0;
    check("b2b captured busy", {31'd0, busy_output}, 32'd1);
    check("b2b captured sum", {16'd0, Sum_output}, 32'd0);
    finish_op("4999+5000", DIGITS, DIGITS + 1, 16'h9999, 1'b0, 1'b0);

    // Start pulses during ADD are ignored
    @(posedge clk); #1;
    d0 = done_cnt;
    launch(16'h1234, 16'h5678, 1'b0);
    @(posedge clk); #1;
    A_input = 16'hFFFF; B_input = 16'hFFFF; start_input = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start_input = 1'b0;
    finish_op("ignore_start", 1, 2, 16'h6912, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("ignore_start done_pulses", done_cnt - d0, 32'd1);
    check("ignore_start no_queue", {31'd0, busy_output}, 32'd0);
    check("ignore_start sum_kept", {16'd0, Sum_output}, 32'h6912);

    // Reset in the middle of the ADD phase
    launch(16'h1234, 16'h5678, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst busy", {31'd0, busy_output}, 32'd0);
    check("midrst sum", {16'd0, Sum_output}, 32'd0);
    check("midrst carry", {31'd0, Carry_output}, 32'd0);
    d0 = done_cnt;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("midrst no_done", done_cnt - d0, 32'd0);
    check("midrst stays_idle", {31'd0, busy_output}, 32'd0);
    run_op("after_rst 9999+0001", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);

    // Non-BCD operand digits: still added with the decimal correction
    run_op("00A0+0001", 16'h00A0, 16'h0001, 1'b0, 16'h0101, 1'b0, CHK);
    run_op("0090+0001", 16'h0090, 16'h0001, 1'b0, 16'h0091, 1'b0, 1'b0);
    run_op("FFFF+FFFF+c", 16'hFFFF, 16'hFFFF, 1'b1, 16'h5555, 1'b1, CHK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
